// File: rtl/npu_sram_pkg.sv
// Shared constants and enums for the NPU result-SRAM access controller.
package npu_sram_pkg;

   localparam int SRAM_C_ADDR_W = 10;
   localparam int SRAM_C_DATA_W = 8;
   localparam int SRAM_C_DEPTH  = 1024;

   typedef enum logic {CTRL_IDLE, CTRL_CLEAR} sram_ctrl_state_t;

   // Encoding doubles as the bit index into the arbiter req/gnt vectors.
   typedef enum logic {REQ_WB, REQ_HOST} req_id_t;

endpackage

// File: rtl/sram_c_ctrl_if.sv
// Request/response bundle for the writeback and host paths into sram_c_ctrl.
interface sram_c_ctrl_if #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 8
);

   logic              wb_valid;
   logic              wb_ready;
   logic [ADDR_W-1:0] wb_addr;
   logic [DATA_W-1:0] wb_data;

   logic              host_valid;
   logic              host_ready;
   logic              host_we;
   logic [ADDR_W-1:0] host_addr;
   logic [DATA_W-1:0] host_wdata;
   logic              host_rvalid;
   logic [DATA_W-1:0] host_rdata;

   modport master (
      output wb_valid, wb_addr, wb_data,
      input  wb_ready,
      output host_valid, host_we, host_addr, host_wdata,
      input  host_ready, host_rvalid, host_rdata
   );

   modport slave (
      input  wb_valid, wb_addr, wb_data,
      output wb_ready,
      input  host_valid, host_we, host_addr, host_wdata,
      output host_ready, host_rvalid, host_rdata
   );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: on a tie the requester that was not granted last wins.
module rr_arb2
   import npu_sram_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       en,
   output logic [1:0] gnt
);

   req_id_t rr_last;

   always_comb begin
      gnt = 2'b00;
      if (en) begin
         case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (rr_last == REQ_HOST) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
         endcase
      end
   end

   // Resetting to HOST lets writeback win the very first tie.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_last <= REQ_HOST;
      end else if (gnt[0]) begin
         rr_last <= REQ_WB;
      end else if (gnt[1]) begin
         rr_last <= REQ_HOST;
      end
   end

endmodule

// File: rtl/sram_C.sv
// 1024x8 single-port result SRAM; read data is registered and valid one cycle after a ce read.
module sram_C #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              ce,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout
);

   logic [DATA_W-1:0] mem [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (ce) begin
         if (we) begin
            mem[addr] <= din;
         end else begin
            dout <= mem[addr];
         end
      end
   end

endmodule

// File: rtl/sram_c_ctrl.sv
// Shares the result SRAM port between PE writeback and host access, and zero-fills
// the whole array on request.
module sram_c_ctrl
   import npu_sram_pkg::*;
#(
   parameter int                ADDR_W    = SRAM_C_ADDR_W,
   parameter int                DATA_W    = SRAM_C_DATA_W,
   parameter int                DEPTH     = SRAM_C_DEPTH,
   parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   sram_c_ctrl_if.slave      bus,
   input  logic              clear_start,
   output logic              clear_busy,
   output logic              clear_done,
   output logic              sram_ce,
   output logic              sram_we,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [DATA_W-1:0] sram_din,
   input  logic [DATA_W-1:0] sram_dout
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   sram_ctrl_state_t  state, state_next;
   logic [ADDR_W-1:0] clear_cnt, clear_cnt_next;
   logic [1:0]        req, gnt;
   logic              arb_en;
   logic              rvalid_next;

   assign req = {bus.host_valid, bus.wb_valid};

   // rst_n gates the grant so the SRAM pins go quiet the moment reset asserts.
   assign arb_en = rst_n && (state == CTRL_IDLE) && !clear_start;

   rr_arb2 u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (req),
      .en    (arb_en),
      .gnt   (gnt)
   );

   always_comb begin
      state_next      = state;
      clear_cnt_next  = clear_cnt;
      clear_done      = 1'b0;
      sram_ce         = 1'b0;
      sram_we         = 1'b0;
      sram_addr       = '0;
      sram_din        = '0;
      bus.wb_ready    = gnt[0];
      bus.host_ready  = gnt[1];
      rvalid_next     = gnt[1] && !bus.host_we;

      case (state)
         CTRL_IDLE: begin
            if (clear_start) begin
               state_next     = CTRL_CLEAR;
               clear_cnt_next = '0;
            end else if (gnt[0]) begin
               sram_ce   = 1'b1;
               sram_we   = 1'b1;
               sram_addr = bus.wb_addr;
               sram_din  = bus.wb_data;
            end else if (gnt[1]) begin
               sram_ce   = 1'b1;
               sram_we   = bus.host_we;
               sram_addr = bus.host_addr;
               sram_din  = bus.host_wdata;
            end
         end
         CTRL_CLEAR: begin
            sram_ce   = 1'b1;
            sram_we   = 1'b1;
            sram_addr = clear_cnt;
            sram_din  = CLEAR_VAL;
            // Terminate on compare so the counter never relies on wrapping.
            if (clear_cnt == LAST_ADDR) begin
               clear_done     = 1'b1;
               state_next     = CTRL_IDLE;
               clear_cnt_next = '0;
            end else begin
               clear_cnt_next = clear_cnt + 1'b1;
            end
         end
         default: begin
            state_next     = CTRL_IDLE;
            clear_cnt_next = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= CTRL_IDLE;
         clear_cnt       <= '0;
         bus.host_rvalid <= 1'b0;
      end else begin
         state           <= state_next;
         clear_cnt       <= clear_cnt_next;
         bus.host_rvalid <= rvalid_next;
      end
   end

   assign clear_busy     = (state == CTRL_CLEAR);
   assign bus.host_rdata = sram_dout;

endmodule

// File: tb/tb_sram_c_ctrl.sv
// Self-checking bench for sram_c_ctrl with the sram_C array attached.
module tb_sram_c_ctrl;
   import npu_sram_pkg::*;

   localparam int AW    = 10;
   localparam int DW    = 8;
   localparam int DEPTH = 1024;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          clear_start, clear_busy, clear_done;
   logic          sram_ce, sram_we;
   logic [AW-1:0] sram_addr;
   logic [DW-1:0] sram_din, sram_dout;

   always #5 clk = ~clk;

   sram_c_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   sram_c_ctrl #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .CLEAR_VAL(8'h00)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus),
      .clear_start (clear_start),
      .clear_busy  (clear_busy),
      .clear_done  (clear_done),
      .sram_ce     (sram_ce),
      .sram_we     (sram_we),
      .sram_addr   (sram_addr),
      .sram_din    (sram_din),
      .sram_dout   (sram_dout)
   );

   sram_C #(.ADDR_W(AW), .DATA_W(DW)) u_sram (
      .clk  (clk),
      .ce   (sram_ce),
      .we   (sram_we),
      .addr (sram_addr),
      .din  (sram_din),
      .dout (sram_dout)
   );

   typedef struct {
      bit            wv;
      logic [AW-1:0] wa;
      logic [DW-1:0] wd;
      bit            hv;
      bit            hwe;
      logic [AW-1:0] ha;
      logic [DW-1:0] hwd;
      bit            cs;
   } stim_t;

   typedef struct {
      bit            wr;
      bit            hr;
      bit            rv;
      logic [DW-1:0] rd;
      bit            busy;
      bit            done;
      bit            ce;
      logic [AW-1:0] addr;
   } obs_t;

   typedef struct {
      stim_t         s;
      bit            exp_wr;
      bit            exp_hr;
      bit            exp_rv;
      logic [DW-1:0] exp_rd;
   } vec_t;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: memory image plus arbitration/clear bookkeeping.
   logic [DW-1:0] mem_m   [DEPTH];
   bit            known_m [DEPTH];
   bit            last_host;
   int            clr_rem;
   int            clr_idx;
   bit            exp_rv;
   logic [DW-1:0] exp_rd;
   bit            exp_known;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   function automatic stim_t mks(bit wv, logic [AW-1:0] wa, logic [DW-1:0] wd,
                                 bit hv, bit hwe, logic [AW-1:0] ha, logic [DW-1:0] hwd, bit cs);
      stim_t s;
      s.wv = wv; s.wa = wa; s.wd = wd;
      s.hv = hv; s.hwe = hwe; s.ha = ha; s.hwd = hwd; s.cs = cs;
      return s;
   endfunction

   function automatic vec_t mkv(stim_t s, bit ewr, bit ehr, bit erv, logic [DW-1:0] erd);
      vec_t v;
      v.s = s; v.exp_wr = ewr; v.exp_hr = ehr; v.exp_rv = erv; v.exp_rd = erd;
      return v;
   endfunction

   function automatic stim_t idleS();
      return mks(0, '0, '0, 0, 0, '0, '0, 0);
   endfunction

   function automatic stim_t wbW(logic [AW-1:0] a, logic [DW-1:0] d);
      return mks(1, a, d, 0, 0, '0, '0, 0);
   endfunction

   function automatic stim_t hostR(logic [AW-1:0] a);
      return mks(0, '0, '0, 1, 0, a, '0, 0);
   endfunction

   function automatic stim_t bothS(logic [AW-1:0] wa, logic [DW-1:0] wd, logic [AW-1:0] ha);
      return mks(1, wa, wd, 1, 0, ha, '0, 0);
   endfunction

   task automatic modelReset();
      last_host = 1'b1;
      clr_rem   = 0;
      clr_idx   = 0;
      exp_rv    = 1'b0;
   endtask

   // One clock cycle: drive, check combinational outputs, clock, check the read return.
   task automatic applyStimulus(input stim_t s, output obs_t o);
      int            g;
      bit            idle;
      logic [31:0]   e_addr, e_din;
      bus.wb_valid   = s.wv;
      bus.wb_addr    = s.wa;
      bus.wb_data    = s.wd;
      bus.host_valid = s.hv;
      bus.host_we    = s.hwe;
      bus.host_addr  = s.ha;
      bus.host_wdata = s.hwd;
      clear_start    = s.cs;
      #1;
      idle = (clr_rem == 0);
      g = 0;
      if (idle && !s.cs) begin
         if (s.wv && s.hv) g = last_host ? 1 : 2;
         else if (s.wv)    g = 1;
         else if (s.hv)    g = 2;
      end
      e_addr = (g == 1) ? 32'(s.wa) : (g == 2) ? 32'(s.ha) : (!idle) ? 32'(clr_idx) : 32'd0;
      e_din  = (g == 1) ? 32'(s.wd) : (g == 2) ? 32'(s.hwd) : 32'd0;
      checkOutput("wb_ready", bus.wb_ready, 32'(g == 1));
      checkOutput("host_ready", bus.host_ready, 32'(g == 2));
      checkOutput("sram_ce", sram_ce, 32'((g != 0) || !idle));
      checkOutput("sram_we", sram_we, 32'((g == 1) || (g == 2 && s.hwe) || !idle));
      checkOutput("sram_addr", sram_addr, e_addr);
      checkOutput("sram_din", sram_din, e_din);
      checkOutput("clear_busy", clear_busy, 32'(!idle));
      checkOutput("clear_done", clear_done, 32'(!idle && clr_idx == DEPTH - 1));
      o.wr   = bus.wb_ready;
      o.hr   = bus.host_ready;
      o.busy = clear_busy;
      o.done = clear_done;
      o.ce   = sram_ce;
      o.addr = sram_addr;
      @(posedge clk);
      exp_rv = (g == 2) && !s.hwe;
      if (exp_rv) begin
         exp_rd    = mem_m[s.ha];
         exp_known = known_m[s.ha];
      end
      if (g == 1) begin
         mem_m[s.wa] = s.wd; known_m[s.wa] = 1'b1; last_host = 1'b0;
      end
      if (g == 2) begin
         if (s.hwe) begin
            mem_m[s.ha] = s.hwd; known_m[s.ha] = 1'b1;
         end
         last_host = 1'b1;
      end
      if (!idle) begin
         mem_m[clr_idx] = 8'h00; known_m[clr_idx] = 1'b1;
         clr_rem--;
         clr_idx = (clr_rem == 0) ? 0 : clr_idx + 1;
      end else if (s.cs) begin
         clr_rem = DEPTH;
         clr_idx = 0;
      end
      #1;
      checkOutput("host_rvalid", bus.host_rvalid, 32'(exp_rv));
      if (exp_rv && exp_known) checkOutput("host_rdata", bus.host_rdata, exp_rd);
      o.rv = bus.host_rvalid;
      o.rd = bus.host_rdata;
   endtask

   task automatic fillAll(input logic [DW-1:0] d);
      obs_t o;
      for (int a = 0; a < DEPTH; a++) applyStimulus(wbW(AW'(a), d), o);
   endtask

   // Runs a clear from its start pulse; optionally re-pulses clear_start at clear cycle restartAt.
   task automatic runClear(input stim_t bg, input int restartAt, input string tag);
      obs_t  o;
      stim_t s;
      int    busyCnt = 0, doneCnt = 0, doneAt = -1;
      logic [AW-1:0] doneAddr = '0;
      s = bg; s.cs = 1'b1;
      applyStimulus(s, o);
      checkOutput({tag, " start wb_ready"}, o.wr, 0);
      checkOutput({tag, " start host_ready"}, o.hr, 0);
      for (int i = 0; i < DEPTH + 80; i++) begin
         s = bg;
         s.cs = (busyCnt == restartAt);
         applyStimulus(s, o);
         if (o.busy) begin
            if (o.done) begin
               doneCnt++; doneAt = busyCnt; doneAddr = o.addr;
            end
            busyCnt++;
         end else if (busyCnt > 0) begin
            break;
         end
      end
      checkOutput({tag, " busy cycles"}, busyCnt, DEPTH);
      checkOutput({tag, " done pulses"}, doneCnt, 1);
      checkOutput({tag, " done cycle"}, doneAt, DEPTH - 1);
      checkOutput({tag, " done addr"}, doneAddr, 32'h3FF);
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      vec_t  vt[$];
      obs_t  o;
      stim_t s;
      bit    wv, hv, hwe;
      logic [AW-1:0] wa, ha;
      logic [DW-1:0] wd, hwd;

      for (int i = 0; i < DEPTH; i++) begin
         mem_m[i] = '0; known_m[i] = 1'b0;
      end
      modelReset();

      // Reset: a pending writeback must not reach the SRAM pins.
      rst_n = 1'b0;
      bus.wb_valid = 1'b1; bus.wb_addr = 10'h155; bus.wb_data = 8'h3C;
      bus.host_valid = 1'b0; bus.host_we = 1'b0; bus.host_addr = '0; bus.host_wdata = '0;
      clear_start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset host_rvalid", bus.host_rvalid, 0);
      checkOutput("reset clear_busy", clear_busy, 0);
      checkOutput("reset clear_done", clear_done, 0);
      checkOutput("reset sram_ce", sram_ce, 0);
      checkOutput("reset sram_we", sram_we, 0);
      checkOutput("reset sram_addr", sram_addr, 0);
      checkOutput("reset sram_din", sram_din, 0);
      bus.wb_valid = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;

      vt.push_back(mkv(wbW(10'h005, 8'hA5), 1, 0, 0, 8'h00));
      vt.push_back(mkv(idleS(),             0, 0, 0, 8'h00));
      vt.push_back(mkv(hostR(10'h005),      0, 1, 1, 8'hA5));
      vt.push_back(mkv(wbW(10'h001, 8'h11), 1, 0, 0, 8'h00));
      vt.push_back(mkv(wbW(10'h002, 8'h22), 1, 0, 0, 8'h00));
      vt.push_back(mkv(wbW(10'h003, 8'h33), 1, 0, 0, 8'h00));
      vt.push_back(mkv(wbW(10'h020, 8'hC0), 1, 0, 0, 8'h00));
      vt.push_back(mkv(wbW(10'h021, 8'hC1), 1, 0, 0, 8'h00));
      vt.push_back(mkv(wbW(10'h022, 8'hC2), 1, 0, 0, 8'h00));
      vt.push_back(mkv(hostR(10'h005),      0, 1, 1, 8'hA5));
      vt.push_back(mkv(bothS(10'h010, 8'h50, 10'h020), 1, 0, 0, 8'h00));
      vt.push_back(mkv(bothS(10'h011, 8'h51, 10'h020), 0, 1, 1, 8'hC0));
      vt.push_back(mkv(bothS(10'h011, 8'h51, 10'h021), 1, 0, 0, 8'h00));
      vt.push_back(mkv(bothS(10'h012, 8'h52, 10'h021), 0, 1, 1, 8'hC1));
      vt.push_back(mkv(bothS(10'h012, 8'h52, 10'h022), 1, 0, 0, 8'h00));
      vt.push_back(mkv(bothS(10'h013, 8'h53, 10'h022), 0, 1, 1, 8'hC2));
      vt.push_back(mkv(wbW(10'h013, 8'h53), 1, 0, 0, 8'h00));
      vt.push_back(mkv(hostR(10'h001),      0, 1, 1, 8'h11));
      vt.push_back(mkv(hostR(10'h002),      0, 1, 1, 8'h22));
      vt.push_back(mkv(hostR(10'h003),      0, 1, 1, 8'h33));
      vt.push_back(mkv(mks(0, '0, '0, 1, 1, 10'h030, 8'h77, 0), 0, 1, 0, 8'h00));
      vt.push_back(mkv(hostR(10'h030),      0, 1, 1, 8'h77));
      vt.push_back(mkv(hostR(10'h011),      0, 1, 1, 8'h51));
      vt.push_back(mkv(idleS(),             0, 0, 0, 8'h00));

      foreach (vt[i]) begin
         applyStimulus(vt[i].s, o);
         checkOutput($sformatf("vec%0d wb_ready", i), o.wr, vt[i].exp_wr);
         checkOutput($sformatf("vec%0d host_ready", i), o.hr, vt[i].exp_hr);
         checkOutput($sformatf("vec%0d host_rvalid", i), o.rv, vt[i].exp_rv);
         if (vt[i].exp_rv) checkOutput($sformatf("vec%0d host_rdata", i), o.rd, vt[i].exp_rd);
      end

      // Full clear with both requesters parked on the bus the whole time.
      fillAll(8'hFF);
      runClear(bothS(10'h000, 8'h00, 10'h1FF), -1, "clear");
      applyStimulus(idleS(), o);
      applyStimulus(hostR(10'h000), o);
      checkOutput("post-clear rd 000", o.rd, 8'h00);
      applyStimulus(hostR(10'h1FF), o);
      checkOutput("post-clear rd 1FF", o.rd, 8'h00);
      applyStimulus(hostR(10'h3FF), o);
      checkOutput("post-clear rd 3FF", o.rd, 8'h00);

      // A second clear_start mid-clear neither restarts nor extends it.
      fillAll(8'hFF);
      runClear(idleS(), 500, "restart");
      applyStimulus(idleS(), o);
      checkOutput("restart no extra clear", o.busy, 0);

      // Reset at clear cycle 300 aborts the fill; words from 300 upward keep 0xFF.
      fillAll(8'hFF);
      applyStimulus(mks(0, '0, '0, 0, 0, '0, '0, 1), o);
      for (int i = 0; i < 300; i++) applyStimulus(idleS(), o);
      rst_n = 1'b0;
      #1;
      checkOutput("abort clear_busy", clear_busy, 0);
      checkOutput("abort sram_ce", sram_ce, 0);
      checkOutput("abort clear_done", clear_done, 0);
      modelReset();
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;
      applyStimulus(hostR(10'h100), o);
      checkOutput("abort rd 100", o.rd, 8'h00);
      applyStimulus(hostR(10'h12B), o);
      checkOutput("abort rd 12B", o.rd, 8'h00);
      applyStimulus(hostR(10'h12C), o);
      checkOutput("abort rd 12C", o.rd, 8'hFF);
      applyStimulus(hostR(10'h200), o);
      checkOutput("abort rd 200", o.rd, 8'hFF);

      // Random traffic; requesters keep their payload until accepted.
      wv = 0; hv = 0; hwe = 0; wa = '0; ha = '0; wd = '0; hwd = '0;
      for (int i = 0; i < 600; i++) begin
         if (!wv && $urandom_range(0, 2) != 0) begin
            wv = 1; wa = AW'($urandom_range(0, DEPTH - 1)); wd = DW'($urandom);
         end
         if (!hv && $urandom_range(0, 2) != 0) begin
            hv = 1; hwe = ($urandom_range(0, 3) == 0);
            ha = AW'($urandom_range(0, DEPTH - 1)); hwd = DW'($urandom);
         end
         s = mks(wv, wa, wd, hv, hwe, ha, hwd, ($urandom_range(0, 299) == 0));
         applyStimulus(s, o);
         if (o.wr) wv = 0;
         if (o.hr) hv = 0;
      end
      applyStimulus(idleS(), o);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/sram_c_ctrl.md
Name: sram_c_ctrl

Overview:
Access controller for the 1024x8 result SRAM (sram_C). It shares the single SRAM port between two requesters: the PE-array writeback path (write-only) and the host access path (read/write). It also contains a zero-fill engine that clears the whole array before a new layer. It drives the SRAM ce/we/addr/din pins directly and returns host read data with a fixed latency.

Parameters:
ADDR_W, 10, SRAM address width
DATA_W, 8, SRAM data width
DEPTH, 1024, number of words; must equal 2**ADDR_W
CLEAR_VAL, 8'h00, value written by the clear engine

Ports:
clk  in  1  clock; all state updates on posedge
rst_n  in  1  asynchronous active-low reset
wb_valid  in  1  writeback request valid
wb_ready  out  1  writeback request accepted this cycle
wb_addr  in  ADDR_W  writeback address
wb_data  in  DATA_W  writeback data
host_valid  in  1  host request valid
host_ready  out  1  host request accepted this cycle
host_we  in  1  1 = write, 0 = read
host_addr  in  ADDR_W  host address
host_wdata  in  DATA_W  host write data
host_rvalid  out  1  host read data valid
host_rdata  out  DATA_W  host read data
clear_start  in  1  single-cycle pulse; starts a zero-fill
clear_busy  out  1  zero-fill in progress
clear_done  out  1  single-cycle pulse on the cycle the last clear write issues
sram_ce  out  1  SRAM chip enable
sram_we  out  1  SRAM write enable
sram_addr  out  ADDR_W  SRAM address
sram_din  out  DATA_W  SRAM write data
sram_dout  in  DATA_W  SRAM read data, registered inside the SRAM, valid 1 cycle after a ce read

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE, clear_cnt=0, rr_last=HOST (so WB wins the first tie).
  - host_rvalid=0, clear_busy=0, clear_done=0.
  - sram_ce/we=0; sram_addr/din=0.
- A handshake completes when valid && ready in the same cycle.
- Requesters hold valid and their payload until ready is seen. Valid must not depend on ready.
- SRAM drive is combinational from the current grant, so the SRAM samples on the same edge the handshake completes.
  - When no grant is active: ce=0, we=0, addr=0, din=0.
- States:
  - IDLE: arbitrate wb and host.
  - CLEAR: zero-fill.
- IDLE arbitration:
  - Only one valid: that requester is granted (ready=1).
  - Both valid: grant the requester that is not rr_last. rr_last updates to the granted requester on every grant.
  - WB grant: ce=1, we=1, addr=wb_addr, din=wb_data.
  - Host grant: ce=1, we=host_we, addr=host_addr, din=host_wdata.
- Host read latency:
  - A host read accepted at edge N gives host_rvalid=1 in cycle N+1, with host_rdata=sram_dout.
  - host_rvalid is a registered pulse that lasts one cycle per read. There is no backpressure on read data.
  - Back-to-back reads are allowed, one per cycle.
- Read-after-write: a host read of an address written at edge N, issued at edge N+1 or later, returns the new data. This is the SRAM's behaviour; there is no bypass logic.
- clear_start in IDLE:
  - Takes effect that same cycle: no grant to wb or host in that cycle, both readies are 0.
  - Next state is CLEAR, clear_cnt=0, clear_busy=1 from the next cycle.
  - A host read accepted in the previous cycle still returns its host_rvalid normally.
- CLEAR:
  - Each cycle: ce=1, we=1, addr=clear_cnt, din=CLEAR_VAL, clear_cnt++.
  - wb_ready=0 and host_ready=0 throughout.
  - On the cycle clear_cnt==DEPTH-1: clear_done=1 (combinational pulse).
  - Next state IDLE, clear_cnt=0, clear_busy=0.
  - Takes exactly DEPTH cycles.
- clear_start while in CLEAR: ignored; no restart, no extension.
- Reset mid-clear: aborts immediately to IDLE. Memory contents are partially cleared; there is no recovery.
- clear_cnt is ADDR_W bits wide and must not wrap past DEPTH-1 (termination is on compare, not on overflow).

Decomposition:
- Package npu_sram_pkg:
  - SRAM_C_ADDR_W=10, SRAM_C_DATA_W=8, SRAM_C_DEPTH=1024.
  - typedef enum logic {CTRL_IDLE, CTRL_CLEAR} sram_ctrl_state_t.
  - typedef enum logic {REQ_WB, REQ_HOST} req_id_t.
- Sub-module rr_arb2: 2-way round-robin arbiter holding rr_last.
  - Inputs: req[1:0] and an enable.
  - Outputs: gnt[1:0] one-hot.
- All other logic lives in sram_c_ctrl.
- The bench instantiates sram_c_ctrl together with sram_C.

Test Plan:
- Reset, then WB writes addr 0x005 data 0xA5; host reads 0x005 two cycles later -> wb_ready=1 on cycle 1; host_rvalid=1 one cycle after host handshake with host_rdata=0xA5.
- wb and host valid continuously for 6 cycles (WB addr 0x010.., host reads 0x020..) -> grants alternate WB,HOST,WB,HOST,WB,HOST; exactly one ready per cycle.
- Host back-to-back reads of 0x001,0x002,0x003 (preloaded 0x11,0x22,0x33) -> host_rvalid high 3 consecutive cycles with rdata 0x11,0x22,0x33.
- Fill memory with 0xFF, pulse clear_start -> clear_busy high exactly 1024 cycles; clear_done one pulse at addr 0x3FF; both readies 0 throughout; subsequent reads of 0x000, 0x1FF, 0x3FF return 0x00.
- Pulse clear_start again at clear cycle 500 -> clear_done still arrives at cycle 1024 after the original start; no extra clear.
- Assert rst_n=0 at clear cycle 300 -> clear_busy=0 and sram_ce=0 immediately (asynchronous); after release the host reads 0x100 -> returns 0x00; reading 0x200 -> returns 0xFF.
